vec_lane_collector: RTL and testbench

//  Downstream neighbour of the lane array. Each cycle it can capture the Res outputs of all

---
 rtl/vec_pkg.sv | 31 +++
 rtl/vec_collector_fifo.sv | 73 +++++++
 rtl/vec_lane_collector.sv | 99 +++++++++
 tb/tb_vec_lane_collector.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// ============================================================================
// Module   : vec_pkg
// Brief    : Shared lane-control types and lane geometry for the vector lanes.
// Revision : 1.0
// ============================================================================
`default_nettype none

package vec_pkg;

  typedef enum logic [1:0] {
    OP_DIVS = 2'b00,
    OP_MULS = 2'b01,
    OP_INC  = 2'b10,
    OP_MODS = 2'b11
  } op_e;

  typedef struct packed {
    op_e  op;
    logic size;
  } lane_ctrl_t;

  localparam int c_LANES  = 4;
  localparam int c_LANE_W = 16;

  function automatic int bytesPerLane(input int laneW);
    return laneW / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vec_collector_fifo.sv
// ============================================================================
// Module   : vec_collector_fifo
// Brief    : Generic synchronous FIFO with occupancy count, flush and async reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vec_collector_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     pushValid,
  output logic                     pushReady,
  input  logic [WIDTH-1:0]         pushData,
  output logic                     popValid,
  input  logic                     popReady,
  output logic [WIDTH-1:0]         popData,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wrPtr;
  logic [c_PTR_W-1:0] r_rdPtr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  // Full is judged on registered count only, so a same-cycle pop never frees a slot.
  assign pushReady = (r_count != c_FULL);
  assign popValid  = (r_count != '0);
  assign w_push    = pushValid && pushReady;
  assign w_pop     = popValid && popReady;
  assign popData   = r_mem[r_rdPtr];
  assign count     = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= pushData;
        r_wrPtr        <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/vec_lane_collector.sv
// ============================================================================
// Module   : vec_lane_collector
// Brief    : Packs lane results into a masked vector-register write and queues
//            it toward writeback. Optional out_zero via VEC_COLLECTOR_ZERO_FLAG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vec_lane_collector
  import vec_pkg::*;
#(
  parameter int LANES  = c_LANES,
  parameter int LANE_W = c_LANE_W,
  parameter int DEPTH  = 2,
  parameter int RA_W   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  in_ctrl,
  input  logic [1:0]                  in_idx,
  input  logic [RA_W-1:0]             in_rd,
  input  logic [LANES*LANE_W-1:0]     in_res,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [RA_W-1:0]             out_rd,
  output logic [LANES*LANE_W-1:0]     out_data,
  output logic [LANES*LANE_W/8-1:0]   out_be,
`ifdef VEC_COLLECTOR_ZERO_FLAG_EN
  output logic                        out_zero,
`endif
  output logic [$clog2(DEPTH):0]      count
);

  localparam int c_DATA_W = LANES * LANE_W;
  localparam int c_BPL    = bytesPerLane(LANE_W);
  localparam int c_BE_W   = LANES * c_BPL;
`ifdef VEC_COLLECTOR_ZERO_FLAG_EN
  localparam int c_ENTRY_W = 1 + RA_W + c_BE_W + c_DATA_W;
`else
  localparam int c_ENTRY_W = RA_W + c_BE_W + c_DATA_W;
`endif

  lane_ctrl_t           w_ctrl;
  logic                 w_unusedSize;
  logic [c_BE_W-1:0]    w_be;
  logic [c_ENTRY_W-1:0] w_pushData;
  logic [c_ENTRY_W-1:0] w_popData;

  // size does not affect packing; the zero flag is resolved at push time.
  assign w_ctrl       = lane_ctrl_t'(in_ctrl);
  assign w_unusedSize = w_ctrl.size;

  // An out-of-range INC index matches no lane, leaving an all-zero mask.
  for (genvar i = 0; i < LANES; i++) begin : g_laneMask
    assign w_be[i*c_BPL +: c_BPL] =
      {c_BPL{(w_ctrl.op != OP_INC) || (32'(in_idx) == i)}};
  end

`ifdef VEC_COLLECTOR_ZERO_FLAG_EN
  logic [c_BE_W-1:0] w_byteNz;
  logic              w_zero;

  for (genvar b = 0; b < c_BE_W; b++) begin : g_byteNz
    assign w_byteNz[b] = w_be[b] & (|in_res[b*8 +: 8]);
  end

  assign w_zero     = ~|w_byteNz;
  assign w_pushData = {w_zero, in_rd, w_be, in_res};
  assign out_zero   = w_popData[c_ENTRY_W-1];
`else
  assign w_pushData = {in_rd, w_be, in_res};
`endif

  vec_collector_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .pushValid (in_valid),
    .pushReady (in_ready),
    .pushData  (w_pushData),
    .popValid  (out_valid),
    .popReady  (out_ready),
    .popData   (w_popData),
    .count     (count)
  );

  assign out_data = w_popData[c_DATA_W-1:0];
  assign out_be   = w_popData[c_DATA_W +: c_BE_W];
  assign out_rd   = w_popData[c_DATA_W + c_BE_W +: RA_W];

endmodule

`default_nettype wire

// File: tb/tb_vec_lane_collector.sv
// ============================================================================
// Module   : tb_vec_lane_collector
// Brief    : Directed self-checking bench for vec_lane_collector.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vec_lane_collector;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_ctrl;
  logic [1:0]  in_idx;
  logic [3:0]  in_rd;
  logic [63:0] in_res;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_rd;
  logic [63:0] out_data;
  logic [7:0]  out_be;
  logic [1:0]  count;
`ifdef VEC_COLLECTOR_ZERO_FLAG_EN
  logic        out_zero;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] c_DIVS = 3'b000;
  localparam logic [2:0] c_MULS = 3'b010;
  localparam logic [2:0] c_INC  = 3'b100;

  vec_lane_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_idx    (in_idx),
    .in_rd     (in_rd),
    .in_res    (in_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rd    (out_rd),
    .out_data  (out_data),
    .out_be    (out_be),
`ifdef VEC_COLLECTOR_ZERO_FLAG_EN
    .out_zero  (out_zero),
`endif
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [1:0] i,
                       input logic [3:0] rd, input logic [63:0] res);
    in_valid = v;
    in_ctrl  = c;
    in_idx   = i;
    in_rd    = rd;
    in_res   = res;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 3'b0, 2'b0, 4'h0, 64'h0);
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_out_data",  out_data,       64'd0);
    chk("rst_out_be",    64'(out_be),    64'd0);
    chk("rst_out_rd",    64'(out_rd),    64'd0);
    #10 rst_n = 1'b1;
    step();

    // MULS push
    out_ready = 1'b1;
    drive(1'b1, c_MULS, 2'd0, 4'd3, 64'h0031_0031_0031_0031);
    step();
    drive(1'b0, c_MULS, 2'd0, 4'd0, 64'h0);
    chk("muls_valid", 64'(out_valid), 64'd1);
    chk("muls_data",  out_data,       64'h0031_0031_0031_0031);
    chk("muls_be",    64'(out_be),    64'hFF);
    chk("muls_rd",    64'(out_rd),    64'd3);
    chk("muls_count", 64'(count),     64'd1);
    step();
    chk("muls_drain", 64'(out_valid), 64'd0);

    // INC idx=1 then idx=0 back to back (push+pop at count=1)
    drive(1'b1, c_INC, 2'd1, 4'd4, 64'h0000_0000_0008_0000);
    step();
    chk("inc1_be",   64'(out_be),   64'h0C);
    chk("inc1_data", out_data,      64'h0000_0000_0008_0000);
    drive(1'b1, c_INC, 2'd0, 4'd5, 64'h0000_0000_0000_0001);
    step();
    chk("inc0_be",    64'(out_be), 64'h03);
    chk("inc0_rd",    64'(out_rd), 64'd5);
    chk("inc0_count", 64'(count),  64'd1);
    drive(1'b0, c_MULS, 2'd0, 4'd0, 64'h0);
    step();
    chk("inc_drain", 64'(count), 64'd0);

    // Back-pressure: A, B accepted, C held
    out_ready = 1'b0;
    drive(1'b1, c_MULS, 2'd0, 4'd1, 64'hAAAA_AAAA_AAAA_AAAA);
    step();
    chk("bp_countA", 64'(count), 64'd1);
    drive(1'b1, c_MULS, 2'd0, 4'd2, 64'hBBBB_BBBB_BBBB_BBBB);
    step();
    chk("bp_countB", 64'(count),    64'd2);
    chk("bp_full",   64'(in_ready), 64'd0);
    drive(1'b1, c_MULS, 2'd0, 4'd3, 64'hCCCC_CCCC_CCCC_CCCC);
    step();
    chk("bp_holdC",  64'(count),  64'd2);
    chk("bp_headA",  64'(out_rd), 64'd1);
    chk("bp_dataA",  out_data,    64'hAAAA_AAAA_AAAA_AAAA);
    out_ready = 1'b1;
    step();
    chk("bp_refuse", 64'(count),  64'd1);
    chk("bp_headB",  64'(out_rd), 64'd2);
    chk("bp_dataB",  out_data,    64'hBBBB_BBBB_BBBB_BBBB);
    step();
    chk("bp_pp_cnt", 64'(count),  64'd1);
    chk("bp_headC",  64'(out_rd), 64'd3);
    chk("bp_dataC",  out_data,    64'hCCCC_CCCC_CCCC_CCCC);
    drive(1'b0, c_MULS, 2'd0, 4'd0, 64'h0);
    step();
    chk("bp_drain", 64'(out_valid), 64'd0);

    // Flush with count=2 and in_valid=1
    out_ready = 1'b0;
    drive(1'b1, c_MULS, 2'd0, 4'd5, 64'h5555_5555_5555_5555);
    step();
    drive(1'b1, c_MULS, 2'd0, 4'd6, 64'h6666_6666_6666_6666);
    step();
    chk("fl_pre", 64'(count), 64'd2);
    flush = 1'b1;
    drive(1'b1, c_MULS, 2'd0, 4'd7, 64'h7777_7777_7777_7777);
    step();
    flush = 1'b0;
    drive(1'b0, c_MULS, 2'd0, 4'd0, 64'h0);
    chk("fl_count", 64'(count),     64'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready),  64'd1);
    out_ready = 1'b1;
    step();
    chk("fl_nolate", 64'(out_valid), 64'd0);

    // Zero-flag vectors (mask checked in every build)
    drive(1'b1, c_INC, 2'd2, 4'd8, 64'h1111_0000_2222_3333);
    step();
    chk("zf_inc_be", 64'(out_be), 64'h30);
`ifdef VEC_COLLECTOR_ZERO_FLAG_EN
    chk("zf_inc_zero", 64'(out_zero), 64'd1);
`endif
    drive(1'b1, c_DIVS, 2'd0, 4'd9, 64'h0000_0000_0000_0100);
    step();
    chk("zf_divs_be", 64'(out_be), 64'hFF);
`ifdef VEC_COLLECTOR_ZERO_FLAG_EN
    chk("zf_divs_zero", 64'(out_zero), 64'd0);
`endif
    drive(1'b0, c_MULS, 2'd0, 4'd0, 64'h0);
    step();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(1'b1, c_MULS, 2'd0, 4'd2, 64'h1234_5678_9ABC_DEF0);
    step();
    drive(1'b0, c_MULS, 2'd0, 4'd0, 64'h0);
    chk("ar_pre", 64'(count), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_count", 64'(count),     64'd0);
    chk("ar_ready", 64'(in_ready),  64'd1);
    #3 rst_n = 1'b1;
    step();
    chk("ar_post", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
